// File: rtl/fpu_pkg.sv
// Shared FPU types and constants used by the iterative divider.
package fpu_pkg;

  localparam int          EXP_BIAS = 127;
  localparam int          EXP_MAX  = 255;
  localparam logic [31:0] QNAN     = 32'h7FC00000;
  localparam logic [31:0] POS_INF  = 32'h7F800000;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } sp_float_t;

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    SPECIAL,
    ROUND,
    DONE
  } div_state_t;

endpackage

// File: rtl/fpu_classify.sv
// Per-operand classification of a single-precision value; subnormals count as zero.
import fpu_pkg::*;

module fpu_classify (
  input  logic [31:0] x,
  output logic        sign,
  output logic        is_zero,
  output logic        is_inf,
  output logic        is_nan
);

  sp_float_t f;

  assign f       = x;
  assign sign    = f.sign;
  assign is_zero = (f.exp == 8'h00);
  assign is_inf  = (f.exp == 8'hFF) && (f.frac == 23'h0);
  assign is_nan  = (f.exp == 8'hFF) && (f.frac != 23'h0);

endmodule

// File: rtl/fpu_div_iter.sv
// Restoring radix-2 single-precision divider, one quotient bit per clock,
// with valid/ready handshakes on input and output.
import fpu_pkg::*;

module fpu_div_iter #(
  parameter bit ROUND_NEAREST = 1'b1,
  parameter int QBITS         = 25
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        div_by_zero,
  output logic        invalid,
  output logic        overflow,
  output logic        underflow,
  output logic        inexact
);

  localparam logic signed [9:0] E_MAX  = 10'(EXP_MAX);
  localparam logic [9:0]        E_BIAS = 10'(EXP_BIAS);

  div_state_t        state;
  logic              sign;
  logic signed [9:0] exp_q;
  logic [23:0]       mb;
  logic [24:0]       rem;
  logic [24:0]       q;
  logic [4:0]        cnt;

  sp_float_t fa, fb;
  logic a_sign, a_zero, a_inf, a_nan;
  logic b_sign, b_zero, b_inf, b_nan;

  assign fa = a;
  assign fb = b;

  fpu_classify u_cls_a (.x(a), .sign(a_sign), .is_zero(a_zero), .is_inf(a_inf), .is_nan(a_nan));
  fpu_classify u_cls_b (.x(b), .sign(b_sign), .is_zero(b_zero), .is_inf(b_inf), .is_nan(b_nan));

  logic        in_sign;
  logic        is_special;
  logic [31:0] spec_res;
  logic        spec_dz, spec_inv;

  assign in_sign = a_sign ^ b_sign;

  always_comb begin
    is_special = 1'b1;
    spec_res   = 32'h0;
    spec_dz    = 1'b0;
    spec_inv   = 1'b0;
    if (a_nan || b_nan) begin
      spec_res = QNAN;
      spec_inv = 1'b1;
    end else if ((a_inf && b_inf) || (a_zero && b_zero)) begin
      spec_res = QNAN;
      spec_inv = 1'b1;
    end else if (a_inf) begin
      spec_res = POS_INF | {in_sign, 31'h0};
    end else if (b_zero) begin
      spec_res = POS_INF | {in_sign, 31'h0};
      spec_dz  = 1'b1;
    end else if (a_zero || b_inf) begin
      spec_res = {in_sign, 31'h0};
    end else begin
      is_special = 1'b0;
    end
  end

  // Pre-normalise so the quotient always lands in [1,2).
  logic [23:0] ma_in, mb_in;
  logic        adj;
  logic [9:0]  exp_in;

  assign ma_in  = {1'b1, fa.frac};
  assign mb_in  = {1'b1, fb.frac};
  assign adj    = (ma_in < mb_in);
  assign exp_in = {2'b00, fa.exp} - {2'b00, fb.exp} + E_BIAS - {9'h0, adj};

  logic              sticky, rnd_up;
  logic [24:0]       mant_inc;
  logic signed [9:0] e_rnd;
  logic [22:0]       frac_rnd;

  assign sticky   = (rem != 25'h0);
  assign rnd_up   = ROUND_NEAREST && q[0] && (sticky || q[1]);
  assign mant_inc = {1'b0, q[24:1]} + {24'h0, rnd_up};
  assign e_rnd    = exp_q + {9'h0, mant_inc[24]};
  assign frac_rnd = mant_inc[24] ? 23'h0 : mant_inc[22:0];

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sign        <= 1'b0;
      exp_q       <= '0;
      mb          <= '0;
      rem         <= '0;
      q           <= '0;
      cnt         <= '0;
      out_valid   <= 1'b0;
      result      <= '0;
      div_by_zero <= 1'b0;
      invalid     <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      inexact     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign <= in_sign;
            if (is_special) begin
              result      <= spec_res;
              div_by_zero <= spec_dz;
              invalid     <= spec_inv;
              overflow    <= 1'b0;
              underflow   <= 1'b0;
              inexact     <= 1'b0;
              state       <= SPECIAL;
            end else begin
              mb    <= mb_in;
              rem   <= adj ? {ma_in, 1'b0} : {1'b0, ma_in};
              exp_q <= exp_in;
              q     <= '0;
              cnt   <= 5'(QBITS - 1);
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (rem >= {1'b0, mb}) begin
            q   <= {q[23:0], 1'b1};
            rem <= (rem - {1'b0, mb}) << 1;
          end else begin
            q   <= {q[23:0], 1'b0};
            rem <= rem << 1;
          end
          cnt <= cnt - 5'd1;
          if (cnt == 5'd0) state <= ROUND;
        end
        ROUND: begin
          div_by_zero <= 1'b0;
          invalid     <= 1'b0;
          if (e_rnd >= E_MAX) begin
            result    <= POS_INF | {sign, 31'h0};
            overflow  <= 1'b1;
            underflow <= 1'b0;
            inexact   <= 1'b1;
          end else if (e_rnd <= 10'sd0) begin
            result    <= {sign, 31'h0};
            overflow  <= 1'b0;
            underflow <= 1'b1;
            inexact   <= 1'b1;
          end else begin
            result    <= {sign, e_rnd[7:0], frac_rnd};
            overflow  <= 1'b0;
            underflow <= 1'b0;
            inexact   <= q[0] | sticky;
          end
          out_valid <= 1'b1;
          state     <= DONE;
        end
        SPECIAL: begin
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_div_iter.sv
// Directed bench for fpu_div_iter: arithmetic, specials, range limits,
// backpressure and reset abort, with a truncating instance alongside.
module tb_fpu_div_iter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] a = 32'h0;
  logic [31:0] b = 32'h0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, div_by_zero, invalid, overflow, underflow, inexact;
  logic [31:0] result;
  logic        in_ready_t, out_valid_t, dz_t, inv_t, ovf_t, unf_t, inx_t;
  logic [31:0] result_t;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fpu_div_iter #(.ROUND_NEAREST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .div_by_zero(div_by_zero), .invalid(invalid),
    .overflow(overflow), .underflow(underflow), .inexact(inexact)
  );

  fpu_div_iter #(.ROUND_NEAREST(1'b0)) dut_t (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_t),
    .a(a), .b(b), .out_valid(out_valid_t), .out_ready(out_ready),
    .result(result_t), .div_by_zero(dz_t), .invalid(inv_t),
    .overflow(ovf_t), .underflow(unf_t), .inexact(inx_t)
  );

  // flag order: {div_by_zero, invalid, overflow, underflow, inexact}
  function automatic logic [31:0] flags();
    return {27'h0, div_by_zero, invalid, overflow, underflow, inexact};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic start_op(input logic [31:0] ta, input logic [31:0] tb_v);
    @(negedge clk);
    a = ta;
    b = tb_v;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 1;
    while (!out_valid && n < 60) begin
      @(posedge clk);
      #1 n++;
    end
  endtask

  task automatic release_out(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk({tag, ".valid_drop"}, {31'h0, out_valid}, 32'h0);
    chk({tag, ".ready_back"}, {31'h0, in_ready}, 32'h1);
  endtask

  task automatic do_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                       input logic [31:0] er, input logic [31:0] er_t,
                       input logic [4:0] ef, input int elat);
    int n;
    start_op(ta, tb_v);
    wait_out(n);
    chk({tag, ".lat"}, n, elat);
    chk({tag, ".result"}, result, er);
    chk({tag, ".result_trunc"}, result_t, er_t);
    chk({tag, ".flags"}, flags(), {27'h0, ef});
    release_out(tag);
  endtask

  initial begin
    int n;
    #1;
    chk("rst.in_ready", {31'h0, in_ready}, 32'h1);
    chk("rst.out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst.result", result, 32'h0);
    chk("rst.flags", flags(), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_op("div6_2",   32'h40C00000, 32'h40000000, 32'h40400000, 32'h40400000, 5'b00000, 27);
    do_op("div1_3",   32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 32'h3EAAAAAA, 5'b00001, 27);
    do_op("div1_0",   32'h3F800000, 32'h00000000, 32'h7F800000, 32'h7F800000, 5'b10000, 2);
    do_op("divm1_0",  32'hBF800000, 32'h00000000, 32'hFF800000, 32'hFF800000, 5'b10000, 2);
    do_op("div0_0",   32'h00000000, 32'h00000000, 32'h7FC00000, 32'h7FC00000, 5'b01000, 2);
    do_op("divinf",   32'h7F800000, 32'h7F800000, 32'h7FC00000, 32'h7FC00000, 5'b01000, 2);
    do_op("divnan",   32'hFFC00001, 32'h3F800000, 32'h7FC00000, 32'h7FC00000, 5'b01000, 2);
    do_op("inf_neg",  32'h7F800000, 32'hC0000000, 32'hFF800000, 32'hFF800000, 5'b00000, 2);
    do_op("zero_x",   32'h80000000, 32'h40000000, 32'h80000000, 32'h80000000, 5'b00000, 2);
    do_op("x_inf",    32'h40000000, 32'hFF800000, 32'h80000000, 32'h80000000, 5'b00000, 2);
    do_op("ovf",      32'h7F000000, 32'h3E800000, 32'h7F800000, 32'h7F800000, 5'b00101, 27);
    do_op("unf",      32'h00800000, 32'h40000000, 32'h00000000, 32'h00000000, 5'b00011, 27);
    do_op("neg_div",  32'hC1200000, 32'h40800000, 32'hC0200000, 32'hC0200000, 5'b00000, 27);

    // Backpressure: result held, second request ignored.
    start_op(32'h40C00000, 32'h40000000);
    wait_out(n);
    chk("bp.lat", n, 27);
    @(negedge clk);
    a = 32'h3F800000;
    b = 32'h40400000;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp.result", result, 32'h40400000);
      chk("bp.flags", flags(), 32'h0);
      chk("bp.in_ready", {31'h0, in_ready}, 32'h0);
      chk("bp.out_valid", {31'h0, out_valid}, 32'h1);
    end
    in_valid = 1'b0;
    release_out("bp");
    repeat (3) @(posedge clk);
    #1;
    chk("bp.no_second", {31'h0, in_ready}, 32'h1);
    chk("bp.no_valid", {31'h0, out_valid}, 32'h0);

    // Reset during CALC aborts the operation.
    start_op(32'h40C00000, 32'h40000000);
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid.out_valid", {31'h0, out_valid}, 32'h0);
    chk("rstmid.in_ready", {31'h0, in_ready}, 32'h1);
    chk("rstmid.result", result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("rstmid.no_result", {31'h0, out_valid}, 32'h0);
    do_op("after_rst", 32'h40C00000, 32'h40000000, 32'h40400000, 32'h40400000, 5'b00000, 27);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpu_div_iter.md
Name: fpu_div_iter

Overview:
Sequential IEEE 754 single-precision divider (A / B) that fills the empty DIV opcode slot of the team FPU. It is the inverse operation of the combinational multiplier. It uses a restoring radix-2 divider, one quotient bit per clock, behind valid/ready handshakes on both sides. It is instantiated beside the FPU and selected when opcode == 2'b10.

Parameters:
ROUND_NEAREST, 1, 1 = round-to-nearest-even using guard+sticky; 0 = truncate (matches adder/multiplier)
QBITS, 25, quotient bits generated (24 mantissa + 1 guard); fixed for single precision, not for override

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operands valid
in_ready  out  1  divider idle, can accept operands
a  in  32  dividend, IEEE 754 single
b  in  32  divisor, IEEE 754 single
out_valid  out  1  result valid; held until accepted
out_ready  in  1  consumer accepts result
result  out  32  quotient, IEEE 754 single
div_by_zero  out  1  finite nonzero / zero
invalid  out  1  0/0, inf/inf, or any NaN operand
overflow  out  1  result rounded to inf from finite operands
underflow  out  1  nonzero result flushed to zero
inexact  out  1  nonzero remainder, guard bit set, overflow, or underflow

Behaviour:
- Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, result=0, all flags=0, internal registers cleared.
- Reset mid-operation aborts the division immediately; no result is produced.
- Subnormal inputs (exp==0) are treated as signed zero.
- State IDLE:
  - in_ready=1.
  - On in_valid & in_ready, register sign = a[31]^b[31] and classify the operands.
  - Special case -> SPECIAL. Otherwise -> CALC.
- Special cases, in priority order:
  - Either operand NaN -> 0x7FC00000, invalid.
  - inf/inf or 0/0 -> 0x7FC00000, invalid.
  - inf/x -> signed inf.
  - x/0 (x finite nonzero) -> signed inf, div_by_zero.
  - 0/x or x/inf -> signed zero.
  - NaN result sign is always 0.
- Setup, on the accept edge:
  - ma={1,a[22:0]}, mb={1,b[22:0]}.
  - If ma<mb: rem=ma<<1, adj=1; else rem=ma, adj=0.
  - Exponent is signed 10-bit: e = ea - eb + 127 - adj.
- CALC: exactly QBITS cycles. Each cycle:
  - If rem>=mb: q={q,1}, rem=(rem-mb)<<1.
  - Else: q={q,0}, rem=rem<<1.
  - rem is 25 bits wide.
  - q[24] is always 1 (quotient is in [1,2)).
- ROUND: 1 cycle.
  - G=q[0], S=(rem!=0).
  - If ROUND_NEAREST: increment mant=q[24:1] when G & (S | q[1]).
  - If the increment carries out: mant=1.0, e=e+1.
  - e>=255 -> signed inf, overflow, inexact.
  - e<=0 -> signed zero, underflow, inexact.
  - Otherwise pack {sign, e[7:0], mant[22:0]}.
  - inexact = G | S.
- SPECIAL: 1 cycle, loads the special-case result and flags.
- DONE:
  - out_valid=1. result and flags stay stable while out_valid & !out_ready.
  - On out_ready: out_valid=0 -> IDLE.
  - in_ready=0 in every state other than IDLE.
- Latency, counted from the accept edge:
  - Normal: out_valid is high after QBITS+2 = 27 rising edges.
  - Special: out_valid is high after 2 edges.
- Throughput: one operation in flight at a time. A new accept is possible the cycle after the output handshake.
- Simultaneous events: an out_ready that is asserted without out_valid is ignored.

Decomposition:
- Shared package fpu_pkg:
  - constants EXP_BIAS=127, EXP_MAX=255, QNAN=32'h7FC00000, POS_INF=32'h7F800000
  - packed struct sp_float_t {sign, exp[7:0], frac[22:0]}
  - enum div_state_t {IDLE, CALC, SPECIAL, ROUND, DONE}
- One combinational sub-module, fpu_classify: per-operand is_zero / is_inf / is_nan from a 32-bit value. Instantiated twice.

Test Plan:
- 6.0/2.0 (0x40C00000 / 0x40000000) -> 0x40400000; no flags; out_valid exactly 27 edges after accept.
- 1.0/3.0 (0x3F800000 / 0x40400000) -> 0x3EAAAAAB with ROUND_NEAREST=1, 0x3EAAAAAA with 0; inexact=1.
- Specials, each with out_valid 2 edges after accept:
  - 1.0/+0 -> 0x7F800000 + div_by_zero.
  - -1.0/+0 (0xBF800000) -> 0xFF800000.
  - 0/0 -> 0x7FC00000 + invalid.
  - 0x7F800000 / 0x7F800000 -> 0x7FC00000 + invalid.
- Range limits:
  - 0x7F000000 / 0x3E800000 -> 0x7F800000, overflow + inexact.
  - 0x00800000 / 0x40000000 -> 0x00000000, underflow + inexact.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> result/flags stable, in_ready=0, a second in_valid is not accepted; release -> in_ready=1 next cycle.
- Reset mid-CALC: assert rst_n=0 at cycle 10 of CALC -> out_valid=0 and in_ready=1 immediately; the next 6.0/2.0 request returns 0x40400000.
